wb_gpio_bank: RTL and testbench

WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

---
 rtl/wb_gpio_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 43 ++++
 rtl/wb_gpio_bank.sv | 103 ++++++++++
 tb/tb_wb_gpio_bank.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register map and field limits for the Wishbone GPIO bank
package wb_gpio_pkg;

    localparam int MAX_BTN = 16;
    localparam int MAX_LED = 16;

    localparam logic [31:0] OFS_LED_OUT    = 32'h00;
    localparam logic [31:0] OFS_LED_OE     = 32'h04;
    localparam logic [31:0] OFS_BTN_STATE  = 32'h08;
    localparam logic [31:0] OFS_IRQ_STATUS = 32'h0C;
    localparam logic [31:0] OFS_IRQ_EN     = 32'h10;
    localparam logic [31:0] WINDOW_BYTES   = 32'h14;

    typedef enum logic [2:0] {
        REG_LED_OUT    = 3'd0,
        REG_LED_OE     = 3'd1,
        REG_BTN_STATE  = 3'd2,
        REG_IRQ_STATUS = 3'd3,
        REG_IRQ_EN     = 3'd4
    } reg_sel_e;

    // Offset is relative to the base; anything below the base wraps to a huge value and misses.
    function automatic logic addr_hit(input logic [31:0] ofs);
        return (ofs < WINDOW_BYTES) && (ofs[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser followed by a counter debouncer for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic state,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (sync2 != state) && (cnt == LAST);
    assign rise   = expire && sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (expire) begin
                state <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_gpio_bank.sv
// rtl/wb_gpio_bank.sv - Wishbone slave with LED outputs, debounced buttons and edge interrupts
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          N_BTN           = 4,
    parameter int          N_LED           = 8,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [31:0]      i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic [N_BTN-1:0] buttons,
    output logic [N_LED-1:0] leds,
    output logic [N_LED-1:0] led_enb,
    output logic             irq
);

    logic [N_LED-1:0] led_out;
    logic [N_LED-1:0] led_oe;
    logic [N_BTN-1:0] irq_status;
    logic [N_BTN-1:0] irq_en;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] btn_rise;

    logic [31:0] offset;
    logic        hit;
    reg_sel_e    sel;
    logic        acc;
    logic        wr;
    logic [31:0] rd_word;
    logic [N_BTN-1:0] status_clr;
    logic        unused_wdata;

    assign unused_wdata = ^i_wb_data;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .btn  (buttons[i]),
            .state(btn_state[i]),
            .rise (btn_rise[i])
        );
    end

    assign offset = i_wb_addr - BASE_ADDR;
    assign hit    = addr_hit(offset);
    assign sel    = reg_sel_e'(offset[4:2]);
    assign acc    = i_wb_cyc && i_wb_stb && !o_wb_ack;
    assign wr     = acc && i_wb_we && hit;

    always_comb begin
        rd_word    = '0;
        status_clr = '0;
        if (hit) begin
            case (sel)
                REG_LED_OUT:    rd_word = 32'(led_out);
                REG_LED_OE:     rd_word = 32'(led_oe);
                REG_BTN_STATE:  rd_word = 32'(btn_state);
                REG_IRQ_STATUS: rd_word = 32'(irq_status);
                REG_IRQ_EN:     rd_word = 32'(irq_en);
                default:        rd_word = '0;
            endcase
        end
        if (wr && sel == REG_IRQ_STATUS) begin
            status_clr = i_wb_data[N_BTN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_wb_ack   <= 1'b0;
            o_wb_data  <= '0;
            led_out    <= '0;
            led_oe     <= '0;
            irq_status <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
        end else begin
            o_wb_ack  <= acc;
            o_wb_data <= (acc && !i_wb_we) ? rd_word : '0;
            if (wr && sel == REG_LED_OUT) led_out <= i_wb_data[N_LED-1:0];
            if (wr && sel == REG_LED_OE)  led_oe  <= i_wb_data[N_LED-1:0];
            if (wr && sel == REG_IRQ_EN)  irq_en  <= i_wb_data[N_BTN-1:0];
            // A fresh rising edge outranks a same-cycle clear so no event is lost.
            irq_status <= (irq_status & ~status_clr) | btn_rise;
            irq        <= |(irq_status & irq_en);
        end
    end

    assign leds    = led_out;
    assign led_enb = ~led_oe;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// tb/tb_wb_gpio_bank.sv - self-checking bench for wb_gpio_bank
module tb_wb_gpio_bank;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int DC = 16;

    logic        clk;
    logic        reset;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic [3:0]  buttons;
    logic [7:0]  leds;
    logic [7:0]  led_enb;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_led_out;
    logic [7:0] m_led_oe;
    logic [3:0] m_en;
    logic [3:0] m_status;
    logic [3:0] m_btn;

    logic [31:0] ofs_tab [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                                  32'h14, 32'h2, 32'h1, 32'hFFFF_FFFC, 32'h100};

    wb_gpio_bank #(
        .BASE_ADDR      (BASE),
        .N_BTN          (4),
        .N_LED          (8),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .i_wb_we  (i_wb_we),
        .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data),
        .o_wb_ack (o_wb_ack),
        .o_wb_data(o_wb_data),
        .buttons  (buttons),
        .leds     (leds),
        .led_enb  (led_enb),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_irq();
        return |(m_status & m_en);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; returns one negedge after the ack cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = wdata;
        lat   = 0;
        rdata = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_wb_ack && lat < 8);
        checks++;
        if (!o_wb_ack) begin
            errors++;
            $display("FAIL wb_timeout addr=%h waited=%0d required_ack=1", addr, lat);
        end
        rdata    = o_wb_data;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int lat;
        reset = 1'b1;
        idle(3);
        checks++;
        if (o_wb_ack !== 1'b0 || o_wb_data !== 32'h0 || leds !== 8'h00 || led_enb !== 8'hFF || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b data=%h leds=%h enb=%h irq=%b required 0/0/00/ff/0",
                     o_wb_ack, o_wb_data, leds, led_enb, irq);
        end
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            wb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, rd, lat);
            checks++;
            if (rd !== 32'h0 || lat != 1) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h lat=%0d required=0 lat=1", i, rd, lat);
            end
        end
    endtask

    task automatic test_idle_no_ack;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                i_wb_cyc = 1'b0;
                i_wb_stb = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (o_wb_ack !== 1'b0 || o_wb_data !== 32'h0) begin
                errors++;
                $display("FAIL idle_no_ack step%0d ack=%b data=%h required 0/0", i, o_wb_ack, o_wb_data);
            end
        end
        i_wb_stb = 1'b0;
        idle(1);
    endtask

    task automatic test_leds;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, BASE + 32'h0, 32'hFFFF_FFA5, rd, lat);
        m_led_out = 8'hA5;
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL led_write_latency got=%0d required=1", lat);
        end
        wb_xfer(1'b1, BASE + 32'h4, 32'h0000_00FF, rd, lat);
        m_led_oe = 8'hFF;
        checks++;
        if (leds !== m_led_out || led_enb !== ~m_led_oe) begin
            errors++;
            $display("FAIL led_pins leds=%h enb=%h required %h/%h", leds, led_enb, m_led_out, ~m_led_oe);
        end
        wb_xfer(1'b0, BASE + 32'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0000_00A5 || lat != 1) begin
            errors++;
            $display("FAIL led_out_read got=%h lat=%0d required=000000a5 lat=1", rd, lat);
        end
        wb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL led_oe_read got=%h required=000000ff", rd);
        end
        checks++;
        if (o_wb_data !== 32'h0 || o_wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL data_idle_zero data=%h ack=%b required 0/0", o_wb_data, o_wb_ack);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int lat;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = BASE + 32'h0;
        i_wb_data = 32'h3C;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ack got=%b required=1", o_wb_ack);
        end
        i_wb_addr = BASE + 32'h10;
        i_wb_data = 32'h5;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b0 || leds !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_gap ack=%b leds=%h required 0/3c", o_wb_ack, leds);
        end
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ack got=%b required=1", o_wb_ack);
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(negedge clk);
        m_led_out = 8'h3C;
        m_en      = 4'h5;
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_en}) begin
            errors++;
            $display("FAIL b2b_irq_en got=%h required=%h", rd, {28'h0, m_en});
        end
    endtask

    task automatic test_invalid_addr;
        logic [31:0] rd;
        int lat;
        logic [31:0] bad [3] = '{BASE + 32'h14, BASE + 32'h2, BASE - 32'h4};
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b1, bad[i], 32'h77, rd, lat);
            wb_xfer(1'b0, bad[i], 32'h0, rd, lat);
            checks++;
            if (rd !== 32'h0 || lat != 1) begin
                errors++;
                $display("FAIL bad_addr_read addr=%h got=%h lat=%0d required=0 lat=1", bad[i], rd, lat);
            end
        end
        wb_xfer(1'b0, BASE + 32'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== {24'h0, m_led_out}) begin
            errors++;
            $display("FAIL bad_addr_led_out got=%h required=%h", rd, {24'h0, m_led_out});
        end
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_en}) begin
            errors++;
            $display("FAIL bad_addr_irq_en got=%h required=%h", rd, {28'h0, m_en});
        end
    endtask

    task automatic test_random_regs;
        logic [31:0] rd;
        logic [31:0] wdata;
        logic [31:0] exp;
        int lat;
        int idx;
        logic we;
        for (int n = 0; n < 40; n++) begin
            idx   = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            case (idx)
                0: exp = {24'h0, m_led_out};
                1: exp = {24'h0, m_led_oe};
                2: exp = {28'h0, m_btn};
                3: exp = {28'h0, m_status};
                4: exp = {28'h0, m_en};
                default: exp = 32'h0;
            endcase
            wb_xfer(we, BASE + ofs_tab[idx], wdata, rd, lat);
            if (we) begin
                case (idx)
                    0: m_led_out = wdata[7:0];
                    1: m_led_oe  = wdata[7:0];
                    3: m_status  = m_status & ~wdata[3:0];
                    4: m_en      = wdata[3:0];
                    default: ;
                endcase
            end else begin
                checks++;
                if (rd !== exp) begin
                    errors++;
                    $display("FAIL rand_read ofs=%h got=%h required=%h", ofs_tab[idx], rd, exp);
                end
            end
            checks++;
            if (leds !== m_led_out || led_enb !== ~m_led_oe || irq !== exp_irq()) begin
                errors++;
                $display("FAIL rand_pins leds=%h enb=%h irq=%b required %h/%h/%b",
                         leds, led_enb, irq, m_led_out, ~m_led_oe, exp_irq());
            end
        end
    endtask

    task automatic test_btn_step;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, BASE + 32'h10, 32'h0, rd, lat);
        m_en = 4'h0;
        buttons[0] = 1'b1;
        idle(DC + 1);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL step_too_early got=%h required=0", rd);
        end
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, lat);
        m_btn = 4'h1;
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL step_btn_state got=%h required=1", rd);
        end
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        m_status = 4'h1;
        checks++;
        if (rd !== 32'h1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL step_status got=%h irq=%b required 1/0", rd, irq);
        end
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = BASE + 32'h10;
        i_wb_data = 32'h1;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_en_edge ack=%b irq=%b required 1/0", o_wb_ack, irq);
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(negedge clk);
        m_en = 4'h1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_en got=%b required=1", irq);
        end
        wb_xfer(1'b1, BASE + 32'hC, 32'h1, rd, lat);
        wb_xfer(1'b1, BASE + 32'h10, 32'h4, rd, lat);
        m_status = 4'h0;
        m_en     = 4'h4;
        idle(1);
        buttons[2] = 1'b1;
        idle(DC + 2);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency_early got=%b required=0", irq);
        end
        idle(1);
        m_status = 4'h4;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_latency_exact got=%b required=1", irq);
        end
        buttons = 4'h0;
        m_btn   = 4'h0;
        idle(DC + 10);
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_status}) begin
            errors++;
            $display("FAIL release_no_status got=%h required=%h", rd, {28'h0, m_status});
        end
        wb_xfer(1'b1, BASE + 32'hC, 32'hF, rd, lat);
        wb_xfer(1'b1, BASE + 32'h10, 32'h0, rd, lat);
        m_status = 4'h0;
        m_en     = 4'h0;
    endtask

    task automatic test_glitch;
        logic [31:0] rd;
        int lat;
        buttons[1] = 1'b1;
        idle(10);
        buttons[1] = 1'b0;
        idle(DC + 10);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch_btn_state got=%h required=0", rd);
        end
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_status}) begin
            errors++;
            $display("FAIL glitch_status got=%h required=%h", rd, {28'h0, m_status});
        end
    endtask

    task automatic test_w1c_collision;
        logic [31:0] rd;
        int lat;
        buttons[0] = 1'b1;
        idle(DC + 10);
        buttons[0] = 1'b0;
        m_status   = 4'h1;
        idle(DC + 10);
        buttons[0] = 1'b1;
        idle(DC + 1);
        wb_xfer(1'b1, BASE + 32'hC, 32'h1, rd, lat);
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL w1c_collision got=%h required=1", rd);
        end
        wb_xfer(1'b1, BASE + 32'hC, 32'h1, rd, lat);
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        m_status = 4'h0;
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_plain got=%h required=0", rd);
        end
        buttons[0] = 1'b0;
        idle(DC + 10);
    endtask

    task automatic test_random_buttons;
        logic [31:0] rd;
        logic [3:0] mask;
        int lat;
        int b;
        int len;
        for (int n = 0; n < 12; n++) begin
            b   = $urandom_range(0, 3);
            len = $urandom_range(1, 2 * DC);
            m_en = 4'($urandom_range(0, 15));
            wb_xfer(1'b1, BASE + 32'h10, {28'h0, m_en}, rd, lat);
            buttons[b] = 1'b1;
            idle(len);
            buttons[b] = 1'b0;
            if (len >= DC) m_status[b] = 1'b1;
            idle(DC + 12);
            wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, lat);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL rbtn_state b=%0d len=%0d got=%h required=0", b, len, rd);
            end
            wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
            checks++;
            if (rd !== {28'h0, m_status} || irq !== exp_irq()) begin
                errors++;
                $display("FAIL rbtn_status b=%0d len=%0d got=%h irq=%b required %h/%b",
                         b, len, rd, irq, {28'h0, m_status}, exp_irq());
            end
            mask = 4'($urandom_range(0, 15));
            wb_xfer(1'b1, BASE + 32'hC, {28'h0, mask}, rd, lat);
            m_status = m_status & ~mask;
        end
    endtask

    task automatic test_reset_mid_transfer;
        logic [31:0] rd;
        int lat;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = BASE + 32'h4;
        i_wb_data = 32'h3C;
        reset     = 1'b1;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b0 || o_wb_data !== 32'h0 || leds !== 8'h00 || led_enb !== 8'hFF || irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset ack=%b data=%h leds=%h enb=%h irq=%b required 0/0/00/ff/0",
                     o_wb_ack, o_wb_data, leds, led_enb, irq);
        end
        reset    = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        m_led_out = 8'h0;
        m_led_oe  = 8'h0;
        m_en      = 4'h0;
        m_status  = 4'h0;
        @(negedge clk);
        checks++;
        if (o_wb_ack !== 1'b0 || led_enb !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_lost ack=%b enb=%h required 0/ff", o_wb_ack, led_enb);
        end
        wb_xfer(1'b1, BASE + 32'h4, 32'h3C, rd, lat);
        m_led_oe = 8'h3C;
        checks++;
        if (led_enb !== ~m_led_oe) begin
            errors++;
            $display("FAIL midreset_retry enb=%h required=%h", led_enb, ~m_led_oe);
        end
    endtask

    task automatic test_reset_held;
        logic [31:0] rd;
        int lat;
        buttons = 4'h8;
        reset   = 1'b1;
        idle(4);
        reset = 1'b0;
        m_led_out = 8'h0;
        m_led_oe  = 8'h0;
        m_en      = 4'h0;
        m_status  = 4'h8;
        m_btn     = 4'h8;
        idle(DC + 12);
        wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_btn}) begin
            errors++;
            $display("FAIL held_btn_state got=%h required=%h", rd, {28'h0, m_btn});
        end
        wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, lat);
        checks++;
        if (rd !== {28'h0, m_status}) begin
            errors++;
            $display("FAIL held_status got=%h required=%h", rd, {28'h0, m_status});
        end
    endtask

    initial begin
        reset     = 1'b1;
        buttons   = 4'h0;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = 32'h0;
        i_wb_data = 32'h0;
        m_led_out = 8'h0;
        m_led_oe  = 8'h0;
        m_en      = 4'h0;
        m_status  = 4'h0;
        m_btn     = 4'h0;
        @(negedge clk);
        test_reset;
        test_idle_no_ack;
        test_leds;
        test_back_to_back;
        test_invalid_addr;
        test_random_regs;
        test_btn_step;
        test_glitch;
        test_w1c_collision;
        test_random_buttons;
        test_reset_mid_transfer;
        test_reset_held;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
